// File: rtl/imm_pkg.sv
// Shared types and encodings for the ID-stage immediate generator.
// Entries are sized for the widest XLEN; narrower instances use the low bits.
package imm_pkg;

    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_ZIMM  = 3'd7
    } imm_type_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef struct packed {
        logic [31:0]         instr;
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] imm;
        imm_type_e           imm_type;
        logic                illegal;
    } imm_entry_t;

    function automatic logic is_shift_f3(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: instruction word -> immediate, type tag, illegal flag.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type,
    output logic            illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm32;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Every format fits in 32 bits sign-extended; widening to XLEN happens once below.
    always_comb begin
        imm32    = '0;
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                if (is_shift_f3(funct3)) begin
                    if (XLEN == 32 && instr[25]) begin
                        illegal = 1'b1;
                    end else begin
                        imm_type = IMM_SHAMT;
                        imm32    = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
                    end
                end else begin
                    imm_type = IMM_I;
                    imm32    = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OPC_LOAD, OPC_JALR: begin
                imm_type = IMM_I;
                imm32    = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_OP_IMM_32: begin
                if (XLEN == 32) begin
                    illegal = 1'b1;
                end else if (funct3 == 3'b001 && instr[31:26] == 6'b000010) begin
                    imm_type = IMM_SHAMT;
                    imm32    = {26'b0, instr[25:20]};
                end else if (is_shift_f3(funct3)) begin
                    imm_type = IMM_SHAMT;
                    imm32    = {27'b0, instr[24:20]};
                end else begin
                    imm_type = IMM_I;
                    imm32    = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OPC_STORE: begin
                imm_type = IMM_S;
                imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                imm_type = IMM_B;
                imm32    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_type = IMM_U;
                imm32    = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                imm_type = IMM_J;
                imm32    = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_SYSTEM: begin
                if (funct3[2]) begin
                    imm_type = IMM_ZIMM;
                    imm32    = {27'b0, instr[19:15]};
                end
            end
            OPC_OP: begin
                imm_type = IMM_NONE;
            end
            OPC_OP_32: begin
                illegal = (XLEN == 32);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    generate
        if (XLEN == 64) begin : g_x64
            assign imm = {{32{imm32[31]}}, imm32};
        end else if (XLEN == 32) begin : g_x32
            assign imm = imm32;
        end else begin : g_bad_xlen
            $error("imm_extract: XLEN must be 32 or 64");
        end
    endgenerate

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generation stage with a 2-entry skid buffer and flush.
// Immediates are computed on the input side so stored entries are final.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int SKID_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic            out_illegal
);

    generate
        if (SKID_DEPTH != 2) begin : g_bad_depth
            $error("imm_gen_pipe: SKID_DEPTH is fixed at 2");
        end
    endgenerate

    logic [XLEN-1:0] ex_imm;
    imm_type_e       ex_type;
    logic            ex_illegal;
    imm_entry_t      in_entry;
    imm_entry_t      main_q;
    imm_entry_t      skid_q;
    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic            in_ready_q;
    logic            accept;
    logic            pop;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr    (in_instr),
        .imm      (ex_imm),
        .imm_type (ex_type),
        .illegal  (ex_illegal)
    );

    always_comb begin
        in_entry          = '0;
        in_entry.instr    = in_instr;
        in_entry.pc       = XLEN_MAX'(in_pc);
        in_entry.imm      = XLEN_MAX'(ex_imm);
        in_entry.imm_type = ex_type;
        in_entry.illegal  = ex_illegal;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready_q;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_ONE;
            ST_ONE: begin
                if (accept && !pop)      state_d = ST_FULL;
                else if (pop && !accept) state_d = ST_EMPTY;
            end
            ST_FULL:  if (pop) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
        if (flush) state_d = ST_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
            if (!flush) begin
                case (state_q)
                    ST_EMPTY: if (accept) main_q <= in_entry;
                    ST_ONE: begin
                        if (accept && pop) main_q <= in_entry;
                        else if (accept)   skid_q <= in_entry;
                    end
                    ST_FULL:  if (pop) main_q <= skid_q;
                    default:  ;
                endcase
            end
        end
    end

    assign out_instr    = main_q.instr;
    assign out_pc       = main_q.pc[XLEN-1:0];
    assign out_imm      = main_q.imm[XLEN-1:0];
    assign out_imm_type = main_q.imm_type;
    assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=64 main instance plus an XLEN=32 instance
// for the width-dependent legality cases.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [63:0] out_imm;
    logic [2:0]  out_imm_type;
    logic        out_illegal;

    logic        in_valid_32 = 1'b0;
    logic        in_ready_32;
    logic [31:0] in_instr_32 = '0;
    logic [31:0] in_pc_32 = '0;
    logic        out_valid_32;
    logic        out_ready_32 = 1'b1;
    logic [31:0] out_instr_32;
    logic [31:0] out_pc_32;
    logic [31:0] out_imm_32;
    logic [2:0]  out_imm_type_32;
    logic        out_illegal_32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .SKID_DEPTH(2)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_imm(out_imm), .out_imm_type(out_imm_type), .out_illegal(out_illegal)
    );

    imm_gen_pipe #(.XLEN(32), .SKID_DEPTH(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid_32), .in_ready(in_ready_32), .in_instr(in_instr_32), .in_pc(in_pc_32),
        .out_valid(out_valid_32), .out_ready(out_ready_32), .out_instr(out_instr_32), .out_pc(out_pc_32),
        .out_imm(out_imm_32), .out_imm_type(out_imm_type_32), .out_illegal(out_illegal_32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addi_k(input int k);
        return {12'(k), 20'h00093};
    endfunction

    task automatic send64(input string tag, input logic [31:0] instr, input logic [63:0] pc,
                          input logic [63:0] exp_imm, input imm_type_e exp_type, input logic exp_ill);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_imm"}, out_imm, exp_imm);
        check({tag, "_type"}, 64'(out_imm_type), 64'(exp_type));
        check({tag, "_illegal"}, 64'(out_illegal), 64'(exp_ill));
        check({tag, "_pc"}, out_pc, pc);
        check({tag, "_instr"}, 64'(out_instr), 64'(instr));
        @(posedge clk); #1;
    endtask

    task automatic send32(input string tag, input logic [31:0] instr,
                          input logic [31:0] exp_imm, input imm_type_e exp_type, input logic exp_ill);
        out_ready_32 = 1'b1;
        in_valid_32  = 1'b1;
        in_instr_32  = instr;
        in_pc_32     = 32'h0000_1000;
        @(posedge clk); #1;
        in_valid_32 = 1'b0;
        check({tag, "_valid"}, 64'(out_valid_32), 64'd1);
        check({tag, "_imm"}, 64'(out_imm_32), 64'(exp_imm));
        check({tag, "_type"}, 64'(out_imm_type_32), 64'(exp_type));
        check({tag, "_illegal"}, 64'(out_illegal_32), 64'(exp_ill));
        @(posedge clk); #1;
    endtask

    initial begin
        int  sent;
        int  got;
        logic acc;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_imm", out_imm, 64'd0);
        check("rst_out_type", 64'(out_imm_type), 64'(IMM_NONE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        send64("addi_m1", 32'hFFF00093, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, IMM_I, 1'b0);
        send64("lui", 32'h800000B7, 64'h0000_0000_8000_0004, 64'hFFFF_FFFF_8000_0000, IMM_U, 1'b0);
        send64("beq_m4", 32'hFE000EE3, 64'h0000_0000_8000_0008, 64'hFFFF_FFFF_FFFF_FFFC, IMM_B, 1'b0);
        send64("slli_uw", 32'h0A81109B, 64'h0000_0000_8000_000C, 64'h28, IMM_SHAMT, 1'b0);
        send64("slli_32", 32'h02001093, 64'h10, 64'h20, IMM_SHAMT, 1'b0);
        send64("sw", 32'h00112623, 64'h14, 64'd12, IMM_S, 1'b0);
        send64("jal", 32'h0080006F, 64'h18, 64'd8, IMM_J, 1'b0);
        send64("csrrwi", 32'h3400D073, 64'h1C, 64'd1, IMM_ZIMM, 1'b0);
        send64("add", 32'h002081B3, 64'h20, 64'd0, IMM_NONE, 1'b0);
        send64("bad_opc", 32'h0000007F, 64'h24, 64'd0, IMM_NONE, 1'b1);

        send32("x32_slli_uw", 32'h0A81109B, 32'd0, IMM_NONE, 1'b1);
        send32("x32_slli_32", 32'h02001093, 32'd0, IMM_NONE, 1'b1);
        send32("x32_addi_m1", 32'hFFF00093, 32'hFFFF_FFFF, IMM_I, 1'b0);
        send32("x32_lui", 32'h800000B7, 32'h8000_0000, IMM_U, 1'b0);

        // Five back-to-back instructions with the consumer stalled for the first three edges.
        sent = 0;
        got  = 1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = (sent < 5);
            in_instr  = addi_k(sent + 1);
            in_pc     = 64'(sent + 1);
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check("stream_order", out_imm, 64'(got));
                got++;
            end
            @(posedge clk); #1;
            if (acc) sent++;
            if (cyc == 0) check("stream_ready_after1", 64'(in_ready), 64'd1);
            if (cyc == 1) check("stream_ready_fall", 64'(in_ready), 64'd0);
            if (cyc == 2) check("stream_ready_held", 64'(in_ready), 64'd0);
            if (cyc == 3) check("stream_ready_rise", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        check("stream_sent", 64'(sent), 64'd5);
        check("stream_got", 64'(got), 64'd6);
        check("stream_drained", 64'(out_valid), 64'd0);

        // Flush from FULL with a simultaneous input that must never appear.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = addi_k(10);
        @(posedge clk); #1;
        in_instr = addi_k(11);
        @(posedge clk); #1;
        check("full_ready", 64'(in_ready), 64'd0);
        flush    = 1'b1;
        in_instr = addi_k(12);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("flush_no_output", 64'(out_valid), 64'd0);
        end
        send64("post_flush", addi_k(13), 64'h40, 64'd13, IMM_I, 1'b0);

        // Asynchronous reset while an entry is held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        in_pc     = 64'hDEAD_BEEF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("areset_pre_valid", 64'(out_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("areset_out_valid", 64'(out_valid), 64'd0);
        check("areset_in_ready", 64'(in_ready), 64'd1);
        check("areset_out_instr", 64'(out_instr), 64'd0);
        check("areset_out_pc", out_pc, 64'd0);
        check("areset_out_imm", out_imm, 64'd0);
        check("areset_out_type", 64'(out_imm_type), 64'(IMM_NONE));
        check("areset_out_illegal", 64'(out_illegal), 64'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("areset_stays_empty", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, registered immediate-generation stage for the ID pipeline. It accepts fetched instructions over a valid/ready handshake and returns each instruction with its XLEN-wide immediate, an immediate-type tag and an illegal flag one cycle later. A 2-entry skid buffer gives a fully registered in_ready. Extends plain I/S/B/U/J extraction with shift-amount (including Zba slli.uw), CSR zimm, XLEN=32/64 support and flush.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64; other values are an elaboration error.
SKID_DEPTH, 2, entries held (main + skid); fixed at 2, exposed for assertions only.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset; asynchronous assert, active-low.
flush  in  1  discard all buffered entries.
in_valid  in  1  upstream instruction valid.
in_ready  out  1  stage can accept; registered.
in_instr  in  32  instruction word.
in_pc  in  XLEN  instruction PC, passed through.
out_valid  out  1  output entry valid.
out_ready  in  1  downstream accepts.
out_instr  out  32  passed-through instruction.
out_pc  out  XLEN  passed-through PC.
out_imm  out  XLEN  extended immediate.
out_imm_type  out  3  imm_type_e tag.
out_illegal  out  1  opcode or shamt not legal for XLEN.

Behaviour:
- Reset: out_valid=0, in_ready=1, out_instr/out_pc/out_imm=0, out_imm_type=IMM_NONE, out_illegal=0, state EMPTY.
- Accept on in_valid&&in_ready. Pop on out_valid&&out_ready. Latency from accept to out_valid is 1 cycle. Order is preserved. Output fields are stable while out_valid&&!out_ready.
- Immediate is computed before registering, so stored entries carry final imm, type and illegal.
- FSM states:
  - EMPTY: accept -> ONE.
  - ONE: accept&&!pop -> FULL (entry goes to skid). pop&&!accept -> EMPTY. Both or neither -> ONE.
  - FULL: in_ready=0. pop -> ONE (skid moves to main). Otherwise stay.
  - in_ready = (next_state != FULL).
- flush is highest priority after reset. Next state is EMPTY with out_valid=0 and in_ready=1. Any entry accepted or popped in the flush cycle is discarded. Reset asserted mid-operation clears state immediately.
- Extraction by opcode. Sign-extend to XLEN from the field MSB unless stated otherwise:
  - I (0010011 non-shift, 0000011, 1100111, 0011011 addiw): instr[31:20].
  - S (0100011): {instr[31:25], instr[11:7]}.
  - B (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U (0110111, 0010111): {instr[31:12], 12'b0}, sign-extended to XLEN.
  - J (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - SHAMT, zero-extended:
    - 0010011 with funct3 001/101: instr[25:20] if XLEN=64, instr[24:20] if XLEN=32.
    - 0011011 with funct3 001/101: instr[24:20].
    - slli.uw (0011011, funct3 001, instr[31:26]=000010): instr[25:20].
  - ZIMM (1110011, funct3[2]=1): instr[19:15] zero-extended. Other SYSTEM and R-type (0110011, 0111011): imm=0, type IMM_NONE, legal.
  - Illegal: unknown opcode; XLEN=32 with 0011011 or 0111011; XLEN=32 shift-immediate with instr[25]=1. Each gives imm=0, type IMM_NONE, illegal=1.

Decomposition:
- Package imm_pkg:
  - imm_type_e {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_ZIMM}.
  - Opcode localparams.
  - Packed struct imm_entry_t {instr, pc, imm, imm_type, illegal}.
- Sub-module imm_extract (parameter XLEN): purely combinational instr -> {imm, imm_type, illegal}. imm_gen_pipe instantiates it once, on the input side, and holds the handshake FSM and two imm_entry_t registers.

Test Plan:
- XLEN=64, in 0xFFF00093 (addi -1), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFFFFFFFFFF, type IMM_I, illegal=0.
- In 0x800000B7 (lui 0x80000) -> out_imm=0xFFFFFFFF80000000, IMM_U. In 0xFE000EE3 (beq -4) -> out_imm=0xFFFFFFFFFFFFFFFC, IMM_B.
- In 0x0A81109B (slli.uw shamt 40) -> out_imm=0x28, IMM_SHAMT. Same word at XLEN=32 -> illegal=1, imm=0.
- Stream 5 instrs with out_ready=0 for 3 cycles:
  - in_ready falls after 2 accepts, rises 1 cycle after the first pop.
  - All 5 emerge in order, with no duplicate or loss.
- In FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flush-cycle input is never output.
- Assert rst_n=0 asynchronously mid-stream -> out_valid drops without waiting for a clock edge, and all outputs take their reset values.
